// File: rtl/sdcard_sim_lat.sv
// Word-addressed SD-card backing store with fixed read/write latency.
// Models busy/done handshaking, byte-lane writes, write-protect and range errors.
module sdcard_sim_lat #(
  parameter int DISK_BYTES = 65536,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 4,
  parameter int WR_LAT     = 8
) (
  input  logic                  w_CLK,
  input  logic                  w_i_sys_rst,
  input  logic [40:0]           w_i_sdcram_addr,
  input  logic                  w_i_sdcram_ren,
  input  logic [DATA_W/8-1:0]   w_i_sdcram_wen,
  input  logic [DATA_W-1:0]     w_i_sdcram_wdata,
  input  logic                  w_i_sd_wp,
  output logic [DATA_W-1:0]     w_o_sdcram_rdata,
  output logic                  w_o_sdcram_busy,
  output logic                  w_o_sdcram_done,
  output logic                  w_o_sdcram_err,
  output logic [31:0]           w_o_rd_cnt,
  output logic [31:0]           w_o_wr_cnt,
  output logic [2:0]            w_sdcram_state
);

  localparam int NB    = DATA_W / 8;
  localparam int AW    = $clog2(DISK_BYTES);
  localparam int OFF   = $clog2(NB);
  localparam int WORDS = DISK_BYTES / NB;
  localparam int IW    = AW - OFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2
  } state_t;

  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [40:0]         addr_q;
  logic [NB-1:0]       wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [31:0]         rd_cnt_q;
  logic [31:0]         wr_cnt_q;

  logic [DATA_W-1:0]   mem [WORDS];

  logic [IW-1:0]       idx;
  logic                oor;
  logic                fin;
  logic                mem_we;
  logic [DATA_W-1:0]   rdata_d;

  // Range check uses the full 41-bit latched address so high bits cannot alias.
  assign idx     = addr_q[AW-1:OFF];
  assign oor     = (addr_q >= 41'(DISK_BYTES));
  assign fin     = (state_q != IDLE) && (cnt_q == 8'd0);
  assign mem_we  = !w_i_sys_rst && fin && (state_q == WR_WAIT) && !oor && !wp_q;
  assign rdata_d = oor ? '0 : mem[idx];

  always_ff @(posedge w_CLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (wen_q[b]) mem[idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge w_CLK) begin
    if (w_i_sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_i_sdcram_ren || (|w_i_sdcram_wen)) begin
            addr_q  <= w_i_sdcram_addr;
            wen_q   <= w_i_sdcram_wen;
            wdata_q <= w_i_sdcram_wdata;
            wp_q    <= w_i_sd_wp;
            busy_q  <= 1'b1;
            if (w_i_sdcram_ren) begin
              state_q <= RD_WAIT;
              cnt_q   <= 8'(RD_LAT - 1);
            end else begin
              state_q <= WR_WAIT;
              cnt_q   <= 8'(WR_LAT - 1);
            end
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (fin) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (state_q == RD_WAIT) begin
              rdata_q  <= rdata_d;
              err_q    <= oor;
              rd_cnt_q <= rd_cnt_q + 32'd1;
            end else begin
              err_q    <= oor | wp_q;
              wr_cnt_q <= wr_cnt_q + 32'd1;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_o_sdcram_rdata = rdata_q;
  assign w_o_sdcram_busy  = busy_q;
  assign w_o_sdcram_done  = done_q;
  assign w_o_sdcram_err   = err_q;
  assign w_o_rd_cnt       = rd_cnt_q;
  assign w_o_wr_cnt       = wr_cnt_q;
  assign w_sdcram_state   = state_q;

endmodule

// File: tb/tb_sdcard_sim_lat.sv
// Directed bench for sdcard_sim_lat: table of single operations plus
// hand-written back-to-back, simultaneous-request and reset-abort sequences.
module tb_sdcard_sim_lat;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 8;
  localparam int NV     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [40:0] addr;
  logic        ren;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic        wp;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic [31:0] rd_cnt, wr_cnt;
  logic [2:0]  state;

  sdcard_sim_lat #(
    .DISK_BYTES(65536), .DATA_W(32), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .w_CLK(clk), .w_i_sys_rst(rst), .w_i_sdcram_addr(addr),
    .w_i_sdcram_ren(ren), .w_i_sdcram_wen(wen), .w_i_sdcram_wdata(wdata),
    .w_i_sd_wp(wp), .w_o_sdcram_rdata(rdata), .w_o_sdcram_busy(busy),
    .w_o_sdcram_done(done), .w_o_sdcram_err(err), .w_o_rd_cnt(rd_cnt),
    .w_o_wr_cnt(wr_cnt), .w_sdcram_state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ren;
    logic [3:0]  wen;
    logic [40:0] addr;
    logic [31:0] wdata;
    logic        wp;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [NV];
  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] last_rd = 32'h0;
  int          exp_rd  = 0;
  int          exp_wr  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Drive at negedge, get accepted at the next posedge, then scramble the
  // inputs so that only the latched copy can be used.
  task automatic start_op(input logic r, input logic [3:0] we, input logic [40:0] a,
                          input logic [31:0] d, input logic p);
    @(negedge clk);
    ren = r; wen = we; addr = a; wdata = d; wp = p;
    @(posedge clk);
    #1;
    ren = 1'b0; wen = 4'h0; addr = 41'h0; wdata = 32'h0; wp = ~p;
  endtask

  task automatic wait_done(output int ncyc, output int nbusy);
    ncyc = -1;
    nbusy = 0;
    for (int i = 1; i <= 300 && ncyc < 0; i++) begin
      @(negedge clk);
      if (done) ncyc = i;
      else if (busy) nbusy++;
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, " rd_cnt"}, 64'(rd_cnt), 64'(exp_rd));
    check({tag, " wr_cnt"}, 64'(wr_cnt), 64'(exp_wr));
  endtask

  initial begin
    int n, nb, lat, ndone;
    vecs[0]  = '{1'b0, 4'hF, 41'h0000C,       32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'h0, 41'h0000C,       32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 4'hF, 41'h00010,       32'hAABBCCDD, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'h5, 41'h00010,       32'h11223344, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 4'h0, 41'h00010,       32'h0,        1'b0, 1'b0, 32'hAA22CC44};
    vecs[5]  = '{1'b0, 4'hF, 41'h00010,       32'h00000000, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 4'h0, 41'h00010,       32'h0,        1'b1, 1'b0, 32'hAA22CC44};
    vecs[7]  = '{1'b1, 4'h0, 41'h10000,       32'h0,        1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 4'hF, 41'h00000,       32'h0F0F0F0F, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 4'hF, 41'h10000,       32'h12345678, 1'b0, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 4'h0, 41'h00000,       32'h0,        1'b0, 1'b0, 32'h0F0F0F0F};
    vecs[11] = '{1'b0, 4'hF, 41'h0FFFC,       32'h13579BDF, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 4'h0, 41'h0FFFC,       32'h0,        1'b0, 1'b0, 32'h13579BDF};
    vecs[13] = '{1'b0, 4'hF, 41'h00020,       32'h0BADF00D, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 4'h0, 41'h00022,       32'h0,        1'b0, 1'b0, 32'h0BADF00D};
    vecs[15] = '{1'b1, 4'h0, 41'h1000000000C, 32'h0,        1'b0, 1'b1, 32'h0};

    rst = 1'b1; ren = 1'b0; wen = 4'h0; addr = 41'h0; wdata = 32'h0; wp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy",  64'(busy),   64'(0));
    check("rst done",  64'(done),   64'(0));
    check("rst err",   64'(err),    64'(0));
    check("rst rdata", 64'(rdata),  64'(0));
    check("rst state", 64'(state),  64'(0));
    check_cnts("rst");
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      start_op(vecs[k].ren, vecs[k].wen, vecs[k].addr, vecs[k].wdata, vecs[k].wp);
      wait_done(n, nb);
      lat = vecs[k].ren ? RD_LAT : WR_LAT;
      if (vecs[k].ren) begin
        exp_rd++;
        last_rd = vecs[k].exp_rdata;
      end else begin
        exp_wr++;
      end
      check($sformatf("v%0d latency", k), 64'(n),    64'(lat + 1));
      check($sformatf("v%0d busy", k),    64'(nb),   64'(lat));
      check($sformatf("v%0d err", k),     64'(err),  64'(vecs[k].exp_err));
      check($sformatf("v%0d rdata", k),   64'(rdata), 64'(last_rd));
      check_cnts($sformatf("v%0d", k));
    end

    // Back-to-back: request held during busy is ignored, then taken in the done cycle.
    start_op(1'b1, 4'h0, 41'h0000C, 32'h0, 1'b0);
    @(negedge clk);
    check("b2b state", 64'(state), 64'(1));
    ren = 1'b1; addr = 41'h00010;
    wait_done(n, nb);
    check("b2b first latency", 64'(n), 64'(RD_LAT));
    check("b2b first rdata", 64'(rdata), 64'(32'hDEADBEEF));
    @(posedge clk);
    #1;
    ren = 1'b0; addr = 41'h0;
    wait_done(n, nb);
    exp_rd += 2;
    last_rd = 32'hAA22CC44;
    check("b2b second latency", 64'(n), 64'(RD_LAT + 1));
    check("b2b second rdata", 64'(rdata), 64'(last_rd));
    check_cnts("b2b");

    // Simultaneous ren and wen: only the read happens.
    start_op(1'b1, 4'hF, 41'h00020, 32'h55555555, 1'b0);
    wait_done(n, nb);
    exp_rd++;
    check("simul latency", 64'(n), 64'(RD_LAT + 1));
    check("simul rdata", 64'(rdata), 64'(32'h0BADF00D));
    check_cnts("simul");
    start_op(1'b1, 4'h0, 41'h00020, 32'h0, 1'b0);
    wait_done(n, nb);
    exp_rd++;
    check("simul mem kept", 64'(rdata), 64'(32'h0BADF00D));
    check_cnts("simul readback");

    // Reset asserted for the edge T+3 of a write; a request during reset is ignored.
    start_op(1'b0, 4'hF, 41'h00020, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    check("rstmid state", 64'(state), 64'(2));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; ren = 1'b1; addr = 41'h0000C;
    @(negedge clk);
    rst = 1'b0; ren = 1'b0; addr = 41'h0;
    exp_rd = 0; exp_wr = 0; last_rd = 32'h0;
    check("rstmid busy",  64'(busy),  64'(0));
    check("rstmid done",  64'(done),  64'(0));
    check("rstmid state", 64'(state), 64'(0));
    check("rstmid rdata", 64'(rdata), 64'(0));
    check_cnts("rstmid");
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("rstmid no activity", 64'(ndone), 64'(0));
    start_op(1'b1, 4'h0, 41'h00020, 32'h0, 1'b0);
    wait_done(n, nb);
    exp_rd++;
    check("rstmid word kept", 64'(rdata), 64'(32'h0BADF00D));
    check("rstmid err", 64'(err), 64'(0));
    check_cnts("rstmid after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
